// File: rtl/ld_st_if.sv
// Pipeline-side and memory-side signals of the load/store unit, bundled as one port.
// The slave modport is the unit; the master modport is the pipeline/memory environment.
interface ld_st_if;
    logic        start;
    logic [2:0]  ldst_ctrl;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        done;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    modport slave (
        input  start, ldst_ctrl, addr, store_data, mem_ready, mem_rdata,
        output mem_req, mem_addr, mem_we, mem_wdata, load_data, done, stall, misalign, bus_err
    );

    modport master (
        output start, ldst_ctrl, addr, store_data, mem_ready, mem_rdata,
        input  mem_req, mem_addr, mem_we, mem_wdata, load_data, done, stall, misalign, bus_err
    );
endinterface

// File: rtl/ld_st_unit.sv
// Byte/half/word load-store unit: aligns stores onto big-endian byte lanes, extends loads,
// and bounds each memory request with an 8-bit timeout.
module ld_st_unit (
    input  logic     clk,
    input  logic     rst,
    ld_st_if.slave   bus
);
    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t             state;
    logic [2:0]         ctrl_q;
    logic [1:0]         off_q;
    logic [CNT_W-1:0]   cnt;
    logic               mem_req_q;
    logic [31:0]        mem_addr_q;
    logic [3:0]         mem_we_q;
    logic [31:0]        mem_wdata_q;
    logic [31:0]        load_data_q;
    logic               done_q;
    logic               misalign_q;
    logic               bus_err_q;

    logic               misaligned_c;
    logic [3:0]         we_c;
    logic [31:0]        wdata_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        ld_c;
    logic               is_load_c;

    // Store lane steering and alignment check on the live request
    always_comb begin
        misaligned_c = 1'b0;
        we_c         = 4'b0000;
        wdata_c      = bus.store_data;
        case (bus.ldst_ctrl)
            OP_LH, OP_LHU: misaligned_c = bus.addr[0];
            OP_LW:         misaligned_c = (bus.addr[1:0] != 2'b00);
            OP_SB: begin
                we_c    = 4'b1000 >> bus.addr[1:0];
                wdata_c = {4{bus.store_data[7:0]}};
            end
            OP_SH: begin
                misaligned_c = bus.addr[0];
                we_c         = bus.addr[1] ? 4'b0011 : 4'b1100;
                wdata_c      = {2{bus.store_data[15:0]}};
            end
            OP_SW: begin
                misaligned_c = (bus.addr[1:0] != 2'b00);
                we_c         = 4'b1111;
            end
            default: ;
        endcase
    end

    // Load extraction from the latched op; byte offset k lives at bits [31-8k -: 8]
    always_comb begin
        byte_c    = 8'(bus.mem_rdata >> {~off_q, 3'b000});
        half_c    = off_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
        is_load_c = (ctrl_q <= OP_LHU);
        case (ctrl_q)
            OP_LB:   ld_c = {{24{byte_c[7]}}, byte_c};
            OP_LBU:  ld_c = {24'd0, byte_c};
            OP_LH:   ld_c = {{16{half_c[15]}}, half_c};
            OP_LHU:  ld_c = {16'd0, half_c};
            default: ld_c = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ctrl_q      <= 3'd0;
            off_q       <= 2'd0;
            cnt         <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_we_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
            load_data_q <= 32'd0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (misaligned_c) begin
                            state      <= ERR;
                            misalign_q <= 1'b1;
                        end else begin
                            state       <= REQ;
                            ctrl_q      <= bus.ldst_ctrl;
                            off_q       <= bus.addr[1:0];
                            cnt         <= '0;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {bus.addr[31:2], 2'b00};
                            mem_we_q    <= we_c;
                            mem_wdata_q <= wdata_c;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        state     <= DONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 4'b0000;
                        done_q    <= 1'b1;
                        if (is_load_c) begin
                            load_data_q <= ld_c;
                        end
                    end else if (cnt == {CNT_W{1'b1}}) begin
                        state     <= ERR;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 4'b0000;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.load_data = load_data_q;
    assign bus.done      = done_q;
    assign bus.misalign  = misalign_q;
    assign bus.bus_err   = bus_err_q;
    // Hold the pipeline while a request is outstanding or being presented
    assign bus.stall     = (state == REQ) || ((state == IDLE) && bus.start);

endmodule

// File: doc/ld_st_unit.md
LD_ST_UNIT -- requirements
Module: ld_st_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: a memory op is presented this cycle; sampled only in IDLE.
REQ-004 SHALL have port ldst_ctrl, input, 3 bits: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-005 SHALL have port addr, input, 32 bits: byte address of the op.
REQ-006 SHALL have port store_data, input, 32 bits: rt value; SB uses bits [7:0], SH uses bits [15:0].
REQ-007 SHALL have port mem_req, output, 1 bit: memory request, held high until accepted.
REQ-008 SHALL have port mem_addr, output, 32 bits: word address, {addr[31:2],2'b00}.
REQ-009 SHALL have port mem_we, output, 4 bits: byte write enables; bit 3 is the byte at offset 0.
REQ-010 SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-011 SHALL have ports mem_ready, input, 1 bit (request accepted/read data valid) and mem_rdata, input, 32 bits (read word).
REQ-012 SHALL have port load_data, output, 32 bits: extended load result.
REQ-013 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have ports stall, output, 1 bit (pipeline hold) and misalign, output, 1 bit (address exception pulse).
REQ-015 SHALL have port bus_err, output, 1 bit: timeout pulse.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, DONE, ERR.
REQ-017 In IDLE with start=1 and a misaligned address, SHALL go to ERR. Misaligned means: halfword op with addr[0]=1; word op with addr[1:0]!=0.
REQ-018 In IDLE with start=1 and an aligned address, SHALL latch ldst_ctrl/addr/store_data, clear the timeout counter, and go to REQ.
REQ-019 In REQ, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be stable from the latched values; mem_we SHALL be 0000 for loads.
REQ-020 In REQ with mem_ready=1, SHALL capture mem_rdata and go to DONE.
REQ-021 In REQ with mem_ready=0 and counter=255, SHALL go to ERR; otherwise the 8-bit counter SHALL increment.
REQ-022 DONE and ERR SHALL last exactly one cycle and return to IDLE.
REQ-023 done=1 only in DONE; misalign=1 only in ERR reached via REQ-017; bus_err=1 only in ERR reached via REQ-021.
REQ-024 stall SHALL be 1 in REQ, and combinationally 1 in IDLE when start=1; otherwise 0.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 Big-endian lanes: byte offset k maps to bits [31-8k:24-8k].
REQ-027 SB SHALL drive we=1000>>addr[1:0] and wdata={4{sd[7:0]}}.
REQ-028 SH SHALL drive we=1100 (addr[1]=0) or 0011 (addr[1]=1) and wdata={2{sd[15:0]}}.
REQ-029 SW SHALL drive we=1111 and wdata=sd.
REQ-030 LB/LBU SHALL select the addressed byte and sign-/zero-extend it; LH/LHU SHALL select the addressed half and sign-/zero-extend it; LW SHALL pass the word.
REQ-031 load_data SHALL be registered, valid in the DONE cycle, held until the next completion; stores SHALL leave it unchanged.
REQ-032 Minimum latency SHALL be 2 cycles from start to done when mem_ready=1 in the first REQ cycle; each wait cycle adds 1.
REQ-033 ERR SHALL never assert mem_req or write memory.

Reset
REQ-034 On rst=1, including mid-REQ, state SHALL become IDLE at the next edge.
REQ-035 After reset, mem_req/done/misalign/bus_err/stall SHALL be 0, mem_we 0000, mem_addr/mem_wdata/load_data 0, and the counter 0.
REQ-036 rst SHALL override start in the same cycle.

Verification
REQ-037 LB, addr=0x103, mem_rdata=0x1122_3380, ready first cycle -> mem_addr=0x100, we=0000, done 2 cycles after start, load_data=0xFFFF_FF80; LBU of the same -> 0x0000_0080.
REQ-038 SH, addr=0x202, sd=0xABCD_1234 -> we=0011, wdata=0x1234_1234, mem_req held through 3 ready-low cycles, done on the cycle after ready.
REQ-039 LW at addr=0x101 -> misalign pulse 1 cycle after start, mem_req never 1, state IDLE next.
REQ-040 LH, ready held low 256 REQ cycles -> bus_err pulse, done never 1.
REQ-041 rst asserted during REQ -> mem_req=0 and stall=0 next cycle; a following LW at 0x40 with rdata=0xDEAD_BEEF completes normally with load_data=0xDEAD_BEEF.
REQ-042 start pulsed in REQ/DONE -> ignored, no extra request.
